// File: rtl/regfile_mp.sv
// Dual-write, dual-read register file with per-entry busy scoreboard.
// Entry 0 reads as zero; optional same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_W-1:0]     raddr1,
    input  logic [ADDR_W-1:0]     raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2,
    output logic                  rbusy1,
    output logic                  rbusy2,
    input  logic                  we1,
    input  logic                  we2,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [ADDR_W-1:0]     waddr2,
    input  logic [DATA_W/8-1:0]   wstrb1,
    input  logic [DATA_W/8-1:0]   wstrb2,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [DATA_W-1:0]     wdata2,
    input  logic                  set_v,
    input  logic [ADDR_W-1:0]     set_addr,
    output logic [15:0]           wr_cnt
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic              commit1, commit2;

    assign commit1 = we1 && (waddr1 != '0) && (|wstrb1);
    assign commit2 = we2 && (waddr2 != '0) && (|wstrb2);

    // Port 2 is applied after port 1 so it wins on bytes both ports strobe.
    always_comb begin
        mem_d = mem_q;
        if (commit1) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb1[b]) mem_d[waddr1][b*8 +: 8] = wdata1[b*8 +: 8];
            end
        end
        if (commit2) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb2[b]) mem_d[waddr2][b*8 +: 8] = wdata2[b*8 +: 8];
            end
        end
        mem_d[0] = '0;
    end

    // Set is applied after the clears so a coincident set leaves the entry busy.
    always_comb begin
        busy_d = busy_q;
        if (commit1) busy_d[waddr1] = 1'b0;
        if (commit2) busy_d[waddr2] = 1'b0;
        if (set_v && (set_addr != '0)) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q + {15'd0, commit1} + {15'd0, commit2};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_q    <= '{default: '0};
            busy_q   <= '0;
            wr_cnt_q <= '0;
        end else begin
            mem_q    <= mem_d;
            busy_q   <= busy_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            assign rdata1 = (raddr1 == '0) ? '0 : mem_d[raddr1];
            assign rdata2 = (raddr2 == '0) ? '0 : mem_d[raddr2];
        end else begin : g_no_bypass
            assign rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
            assign rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];
        end
    endgenerate

    assign rbusy1 = busy_q[raddr1];
    assign rbusy2 = busy_q[raddr2];
    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized checks of regfile_mp (forwarding and non-forwarding
// builds side by side) against a byte-mask reference model.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  raddr1, raddr2, waddr1, waddr2, set_addr;
    logic        we1, we2, set_v;
    logic [3:0]  wstrb1, wstrb2;
    logic [31:0] wdata1, wdata2;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        bz1_b, bz2_b, bz1_n, bz2_n;
    logic [15:0] cnt_b, cnt_n;

    int checks = 0;
    int failures = 0;

    logic [31:0] ref_mem [32];
    logic        ref_busy [32];
    logic [15:0] ref_cnt;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b (
        .clk(clk), .resetn(resetn),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b),
        .rbusy1(bz1_b), .rbusy2(bz2_b),
        .we1(we1), .we2(we2), .waddr1(waddr1), .waddr2(waddr2),
        .wstrb1(wstrb1), .wstrb2(wstrb2), .wdata1(wdata1), .wdata2(wdata2),
        .set_v(set_v), .set_addr(set_addr), .wr_cnt(cnt_b)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_n (
        .clk(clk), .resetn(resetn),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n),
        .rbusy1(bz1_n), .rbusy2(bz2_n),
        .we1(we1), .we2(we2), .waddr1(waddr1), .waddr2(waddr2),
        .wstrb1(wstrb1), .wstrb2(wstrb2), .wdata1(wdata1), .wdata2(wdata2),
        .set_v(set_v), .set_addr(set_addr), .wr_cnt(cnt_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] smask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic bit c1();
        return we1 && waddr1 != 0 && wstrb1 != 0;
    endfunction

    function automatic bit c2();
        return we2 && waddr2 != 0 && wstrb2 != 0;
    endfunction

    // Value an entry holds once this cycle's writes land.
    function automatic logic [31:0] merged(input int a);
        logic [31:0] v;
        v = ref_mem[a];
        if (c1() && waddr1 == a) v = (v & ~smask(wstrb1)) | (wdata1 & smask(wstrb1));
        if (c2() && waddr2 == a) v = (v & ~smask(wstrb2)) | (wdata2 & smask(wstrb2));
        return v;
    endfunction

    function automatic logic [31:0] exp_read(input int a, input bit byp);
        if (a == 0) return 32'd0;
        return byp ? merged(a) : ref_mem[a];
    endfunction

    task automatic drive_idle();
        we1 = 0; we2 = 0; set_v = 0;
        waddr1 = 0; waddr2 = 0; set_addr = 0;
        wstrb1 = 0; wstrb2 = 0; wdata1 = 0; wdata2 = 0;
    endtask

    task automatic tick();
        logic [31:0] n1, n2;
        logic [15:0] ncnt;
        bit k1, k2;
        k1 = c1(); k2 = c2();
        n1 = merged(waddr1); n2 = merged(waddr2);
        ncnt = ref_cnt + 16'(k1) + 16'(k2);
        @(posedge clk);
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                ref_mem[i] = 0;
                ref_busy[i] = 0;
            end
            ref_cnt = 0;
        end else begin
            if (k1) begin ref_mem[waddr1] = n1; ref_busy[waddr1] = 0; end
            if (k2) begin ref_mem[waddr2] = n2; ref_busy[waddr2] = 0; end
            if (set_v && set_addr != 0) ref_busy[set_addr] = 1;
            ref_cnt = ncnt;
        end
        #1;
    endtask

    task automatic check_reads(input string tag);
        chk({tag, "_rd1_byp"}, rd1_b, exp_read(raddr1, 1));
        chk({tag, "_rd2_byp"}, rd2_b, exp_read(raddr2, 1));
        chk({tag, "_rd1_nobyp"}, rd1_n, exp_read(raddr1, 0));
        chk({tag, "_rd2_nobyp"}, rd2_n, exp_read(raddr2, 0));
        chk({tag, "_busy1"}, {31'd0, bz1_b}, {31'd0, ref_busy[raddr1]});
        chk({tag, "_busy2"}, {31'd0, bz2_n}, {31'd0, ref_busy[raddr2]});
        chk({tag, "_cnt_byp"}, {16'd0, cnt_b}, {16'd0, ref_cnt});
        chk({tag, "_cnt_nobyp"}, {16'd0, cnt_n}, {16'd0, ref_cnt});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin ref_mem[i] = 0; ref_busy[i] = 0; end
        ref_cnt = 0;
        drive_idle();
        raddr1 = 0; raddr2 = 0;
        resetn = 0;
        tick(); tick();
        resetn = 1;

        // Everything reads zero and idle after reset.
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a); #1;
            chk("rst_rd1", rd1_b, 32'd0);
            chk("rst_rd2", rd2_n, 32'd0);
            chk("rst_busy", {30'd0, bz1_b, bz2_n}, 32'd0);
        end
        chk("rst_cnt", {16'd0, cnt_b}, 32'd0);

        // Partial-strobe write.
        we1 = 1; waddr1 = 3; wdata1 = 32'hAABBCCDD; wstrb1 = 4'b0101;
        tick(); drive_idle(); raddr1 = 3; #1;
        chk("strb_rd", rd1_n, 32'h00BB00DD);
        chk("strb_cnt", {16'd0, cnt_b}, 32'd1);

        // Both ports on one address; port 2 wins its bytes.
        we1 = 1; waddr1 = 7; wdata1 = 32'h11111111; wstrb1 = 4'hF;
        we2 = 1; waddr2 = 7; wdata2 = 32'h22222222; wstrb2 = 4'b0011;
        tick(); drive_idle(); raddr2 = 7; #1;
        chk("merge_rd", rd2_b, 32'h11112222);
        chk("merge_cnt", {16'd0, cnt_n}, 32'd3);

        // Same-cycle forwarding versus pre-write value.
        raddr1 = 9; we1 = 1; waddr1 = 9; wdata1 = 32'h5A5A5A5A; wstrb1 = 4'hF; #1;
        chk("fwd_byp", rd1_b, 32'h5A5A5A5A);
        chk("fwd_nobyp_old", rd1_n, 32'd0);
        tick(); drive_idle(); #1;
        chk("fwd_nobyp_new", rd1_n, 32'h5A5A5A5A);
        chk("fwd_cnt", {16'd0, cnt_b}, 32'd4);

        // Scoreboard: set, set+clear, clear.
        set_v = 1; set_addr = 4; raddr1 = 4;
        tick(); drive_idle(); #1;
        chk("sb_set", {31'd0, bz1_b}, 32'd1);
        set_v = 1; set_addr = 4; we2 = 1; waddr2 = 4; wdata2 = 32'h44; wstrb2 = 4'hF;
        tick(); drive_idle(); #1;
        chk("sb_set_wins", {31'd0, bz1_n}, 32'd1);
        we2 = 1; waddr2 = 4; wdata2 = 32'h45; wstrb2 = 4'hF;
        tick(); drive_idle(); #1;
        chk("sb_clear", {31'd0, bz1_b}, 32'd0);
        chk("sb_cnt", {16'd0, cnt_b}, 32'd6);

        // Address 0 writes vanish; reset beats a coincident write.
        raddr1 = 0; we1 = 1; waddr1 = 0; wdata1 = 32'hFFFFFFFF; wstrb1 = 4'hF;
        we2 = 1; waddr2 = 0; wdata2 = 32'hFFFFFFFF; wstrb2 = 4'hF; set_v = 1; set_addr = 0; #1;
        chk("z_rd_fwd", rd1_b, 32'd0);
        tick(); drive_idle(); #1;
        chk("z_rd", rd1_b, 32'd0);
        chk("z_busy", {31'd0, bz1_b}, 32'd0);
        chk("z_cnt", {16'd0, cnt_n}, 32'd6);
        resetn = 0; we1 = 1; waddr1 = 5; wdata1 = 32'hCAFEF00D; wstrb1 = 4'hF;
        set_v = 1; set_addr = 6;
        tick(); drive_idle(); resetn = 1; raddr1 = 5; raddr2 = 3; #1;
        chk("rstw_rd5", rd1_b, 32'd0);
        chk("rstw_rd3", rd2_n, 32'd0);
        chk("rstw_cnt", {16'd0, cnt_b}, 32'd0);
        raddr1 = 6; #1;
        chk("rstw_busy6", {31'd0, bz1_n}, 32'd0);

        // Randomized traffic concentrated on a few addresses to force collisions.
        for (int i = 0; i < 400; i++) begin
            resetn = ($urandom_range(0, 49) != 0);
            we1 = 1'($urandom_range(0, 1)); we2 = 1'($urandom_range(0, 1));
            waddr1 = 5'($urandom_range(0, 7)); waddr2 = 5'($urandom_range(0, 7));
            wstrb1 = 4'($urandom); wstrb2 = 4'($urandom);
            wdata1 = $urandom; wdata2 = $urandom;
            set_v = 1'($urandom_range(0, 1)); set_addr = 5'($urandom_range(0, 7));
            raddr1 = $urandom_range(0, 1) ? waddr1 : 5'($urandom_range(0, 7));
            raddr2 = $urandom_range(0, 1) ? waddr2 : 5'($urandom_range(0, 7));
            #1;
            if (resetn) check_reads("rand");
            tick();
        end
        drive_idle(); resetn = 1;
        for (int a = 0; a < 8; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(7 - a); #1;
            check_reads("final");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, 32, register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, 5, address width; depth is 2**ADDR_W entries, entry 0 hard-wired to zero.
REQ-003 Parameter BYPASS, 1, enables the same-cycle write-to-read forwarding path when set to 1.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 raddr1/raddr2  input  ADDR_W each  read addresses, ports 1 and 2.
REQ-007 rdata1/rdata2  output  DATA_W each  read data, ports 1 and 2.
REQ-008 rbusy1/rbusy2  output  1 each  scoreboard busy bit of raddr1/raddr2.
REQ-009 we1/we2  input  1 each  write enables, ports 1 and 2.
REQ-010 waddr1/waddr2  input  ADDR_W each  write addresses.
REQ-011 wstrb1/wstrb2  input  DATA_W/8 each  byte strobes; bit i qualifies byte i.
REQ-012 wdata1/wdata2  input  DATA_W each  write data.
REQ-013 set_v  input  1  marks the register at set_addr busy (producer issued).
REQ-014 set_addr  input  ADDR_W  register to mark busy.
REQ-015 wr_cnt  output  16  count of committed write-port operations.

Function
REQ-016 A write port SHALL commit on the clk edge when its we is 1, its waddr is nonzero, and at least one wstrb bit is 1; only strobed bytes are updated.
REQ-017 Writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0 with busy 0.
REQ-018 When both ports write the same nonzero address in one cycle, the two writes SHALL merge per byte, with port 2 taking priority on bytes strobed by both.
REQ-019 Reads SHALL be combinational from stored state (zero latency).
REQ-020 With BYPASS=1, each read port SHALL return the merged post-write value of any byte committing this cycle to its address, applying REQ-018 priority.
REQ-021 With BYPASS=0, a read in the same cycle as a write SHALL return the pre-write value, and the new value SHALL be visible on the next cycle.
REQ-022 The scoreboard SHALL hold one busy bit per entry, with entry 0 constantly 0.
REQ-023 A committed write SHALL clear the busy bit of its address on the next edge.
REQ-024 When set_v is 1 and set_addr is nonzero, the busy bit of set_addr SHALL be set on the next edge.
REQ-025 When a set and a clear hit the same address in one cycle, the set SHALL win and the bit ends busy.
REQ-026 rbusy1/rbusy2 SHALL reflect stored busy bits without bypass, whatever the value of BYPASS.
REQ-027 wr_cnt SHALL add the number of ports committing each cycle (0, 1 or 2), wrapping modulo 2**16.
REQ-028 Two ports committing to the same address SHALL count as 2 in wr_cnt.

Reset
REQ-029 While resetn=0 at an edge, all entries SHALL clear to 0, all busy bits to 0, and wr_cnt to 0.
REQ-030 Reset SHALL take priority over any same-cycle write or set.
REQ-031 After reset, rdata1/rdata2 SHALL read 0 and rbusy1/rbusy2 SHALL read 0 for every address.
REQ-032 Reset asserted mid-operation SHALL discard in-flight writes and sets with no partial update.

Verification
REQ-033 Reset, then read all 32 addresses on both ports -> every read returns 0 with busy 0, and wr_cnt=0.
REQ-034 we1 to addr 3 with data 0xAABBCCDD and strobe 0b0101, prior value 0 -> addr 3 reads 0x00BB00DD, and wr_cnt=1.
REQ-035 Same cycle: we1 to addr 7 with 0x11111111, strobe F, and we2 to addr 7 with 0x22222222, strobe 0b0011 -> addr 7 reads 0x11112222, and wr_cnt increments by 2.
REQ-036 BYPASS=1, raddr1=9 while writing 0x5A5A5A5A to addr 9 -> rdata1=0x5A5A5A5A in the same cycle; with BYPASS=0, the old value is returned.
REQ-037 set_v on addr 4 -> rbusy=1 the next cycle; then set_v on addr 4 and we2 on addr 4 in the same cycle -> still busy; then write only -> busy=0.
REQ-038 Writes to addr 0 with all strobes set, and resetn=0 coinciding with a write to addr 5 -> addr 0 reads 0, addr 5 reads 0, and the count is unchanged by the addr-0 write.
